// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath width, reset vector, branch funct3
// encodings and the PC unit's control states.
package core_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pcState_t;

endpackage

// File: rtl/branch_cond.sv
// Turns the comparator flags into a branch-taken condition for a funct3 code
// and flags the two reserved encodings.
module branch_cond
  import core_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       brEq,
  input  logic       brLt,
  output logic       cond,
  output logic       illegal
);

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:           cond = brEq;
      F3_BNE:           cond = !brEq;
      F3_BLT, F3_BLTU:  cond = brLt;
      F3_BGE, F3_BGEU:  cond = !brLt;
      default:          illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Resolves the execute-stage branch/jump, owns the fetch PC and sequences the
// post-redirect flush window.
module branch_pc_unit
  import core_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            instValid,
  input  logic            isBranch,
  input  logic            isJal,
  input  logic            isJalr,
  input  logic [2:0]      funct3,
  input  logic            brEq,
  input  logic            brLt,
  input  logic [XLEN-1:0] aluOut,
  output logic            brUn,
  output logic            pcSel,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4,
  output logic            flush,
  output logic            misalignTrap,
  output logic            illegalBr
);

  pcState_t        state;
  logic [1:0]      flushCnt;
  logic            cond;
  logic            illegal;
  logic            accept;
  logic            jalrSel;
  logic            branchSel;
  logic            take;
  logic [XLEN-1:0] target;

  branch_cond uCond (
    .funct3  (funct3),
    .brEq    (brEq),
    .brLt    (brLt),
    .cond    (cond),
    .illegal (illegal)
  );

  // Decoder conflicts resolve as JAL > JALR > branch.
  assign jalrSel   = isJalr & !isJal;
  assign branchSel = isBranch & !isJal & !isJalr;

  assign brUn    = funct3[1];
  assign accept  = instValid & !stall & (state == RUN);
  assign take    = accept & (isJal | jalrSel | (branchSel & cond));
  assign target  = jalrSel ? {aluOut[XLEN-1:1], 1'b0} : aluOut;
  assign pcSel   = take & !target[1];
  assign pcPlus4 = pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      state        <= RUN;
      flushCnt     <= 2'd0;
      flush        <= 1'b0;
      misalignTrap <= 1'b0;
      illegalBr    <= 1'b0;
    end else begin
      // Trap pulses are not frozen by stall: take/accept already gate on it.
      misalignTrap <= take & target[1];
      illegalBr    <= accept & branchSel & illegal;
      if (!stall) begin
        pc <= pcSel ? target : pcPlus4;
        case (state)
          RUN: begin
            if (pcSel) begin
              state    <= FLUSH;
              flushCnt <= 2'(FLUSH_CYCLES);
              flush    <= 1'b1;
            end
          end
          FLUSH: begin
            flushCnt <= flushCnt - 2'd1;
            if (flushCnt == 2'd1) begin
              state <= RUN;
              flush <= 1'b0;
            end
          end
          default: begin
            state <= RUN;
            flush <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit with RESET_PC=0x100 and a 2-cycle flush.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, instValid, isBranch, isJal, isJalr;
  logic [2:0]  funct3;
  logic        brEq, brLt;
  logic [31:0] aluOut;
  logic        brUn, pcSel, flush, misalignTrap, illegalBr;
  logic [31:0] pc, pcPlus4;
  int          nChecks = 0;
  int          nFails  = 0;

  branch_pc_unit #(.XLEN(32), .RESET_PC(32'h0000_0100), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instValid(instValid),
    .isBranch(isBranch), .isJal(isJal), .isJalr(isJalr), .funct3(funct3),
    .brEq(brEq), .brLt(brLt), .aluOut(aluOut), .brUn(brUn), .pcSel(pcSel),
    .pc(pc), .pcPlus4(pcPlus4), .flush(flush), .misalignTrap(misalignTrap),
    .illegalBr(illegalBr)
  );

  always #5 clk = ~clk;

  task automatic idle();
    stall = 0; instValid = 0; isBranch = 0; isJal = 0; isJalr = 0;
    funct3 = 3'b000; brEq = 0; brLt = 0; aluOut = 32'h0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic br, input logic jal, input logic jalr,
                       input logic [2:0] f3, input logic eq, input logic lt,
                       input logic [31:0] tgt);
    instValid = 1; isBranch = br; isJal = jal; isJalr = jalr;
    funct3 = f3; brEq = eq; brLt = lt; aluOut = tgt;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    tick();
    rst = 0;
    nChecks++; if (pc !== 32'h100) begin nFails++; $display("FAIL reset_pc: got %h want %h", pc, 32'h100); end
    nChecks++; if (flush !== 1'b0) begin nFails++; $display("FAIL reset_flush: got %b want 0", flush); end
    nChecks++; if ({misalignTrap, illegalBr} !== 2'b00) begin nFails++; $display("FAIL reset_traps: got %b want 00", {misalignTrap, illegalBr}); end
    nChecks++; if (pcSel !== 1'b0) begin nFails++; $display("FAIL reset_pcsel: got %b want 0", pcSel); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      nChecks++; if (pc !== 32'h100 + 32'(4 * i)) begin nFails++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, 32'h100 + 32'(4 * i)); end
      nChecks++; if (flush !== 1'b0 || pcSel !== 1'b0) begin nFails++; $display("FAIL seq_ctl%0d: got flush=%b pcSel=%b want 0 0", i, flush, pcSel); end
    end
    tick();  // pc = 0x110
  endtask

  task automatic test_blt_flush();
    drive(1, 0, 0, 3'b100, 0, 1, 32'h200);
    nChecks++; if (brUn !== 1'b0) begin nFails++; $display("FAIL blt_brun: got %b want 0", brUn); end
    nChecks++; if (pcSel !== 1'b1) begin nFails++; $display("FAIL blt_pcsel: got %b want 1", pcSel); end
    tick();
    nChecks++; if (pc !== 32'h200 || flush !== 1'b1) begin nFails++; $display("FAIL blt_redirect: got pc=%h flush=%b want 200 1", pc, flush); end
    drive(1, 0, 0, 3'b000, 1, 0, 32'h500);  // taken BEQ that must be ignored
    nChecks++; if (pcSel !== 1'b0) begin nFails++; $display("FAIL flush_ignore1: got pcSel=%b want 0", pcSel); end
    tick();
    nChecks++; if (pc !== 32'h204 || flush !== 1'b1) begin nFails++; $display("FAIL flush_cyc2: got pc=%h flush=%b want 204 1", pc, flush); end
    nChecks++; if (pcSel !== 1'b0) begin nFails++; $display("FAIL flush_ignore2: got pcSel=%b want 0", pcSel); end
    tick();
    idle();
    nChecks++; if (pc !== 32'h208 || flush !== 1'b0) begin nFails++; $display("FAIL flush_end: got pc=%h flush=%b want 208 0", pc, flush); end
  endtask

  task automatic test_bgeu();
    drive(1, 0, 0, 3'b111, 0, 1, 32'h40);
    nChecks++; if (brUn !== 1'b1 || pcSel !== 1'b0) begin nFails++; $display("FAIL bgeu_nt: got brUn=%b pcSel=%b want 1 0", brUn, pcSel); end
    tick();
    nChecks++; if (pc !== 32'h20C) begin nFails++; $display("FAIL bgeu_nt_pc: got %h want 20c", pc); end
    drive(1, 0, 0, 3'b111, 0, 0, 32'h40);
    nChecks++; if (pcSel !== 1'b1) begin nFails++; $display("FAIL bgeu_t: got pcSel=%b want 1", pcSel); end
    tick();
    idle();
    nChecks++; if (pc !== 32'h40) begin nFails++; $display("FAIL bgeu_t_pc: got %h want 40", pc); end
    tick(); tick();
    nChecks++; if (pc !== 32'h48 || flush !== 1'b0) begin nFails++; $display("FAIL bgeu_after: got pc=%h flush=%b want 48 0", pc, flush); end
  endtask

  task automatic test_jumps();
    drive(0, 0, 1, 3'b000, 0, 0, 32'h301);
    nChecks++; if (pcSel !== 1'b1) begin nFails++; $display("FAIL jalr_pcsel: got %b want 1", pcSel); end
    tick();
    idle();
    nChecks++; if (pc !== 32'h300) begin nFails++; $display("FAIL jalr_pc: got %h want 300", pc); end
    tick(); tick();  // pc = 0x308, back in RUN
    drive(0, 1, 0, 3'b000, 0, 0, 32'h302);
    nChecks++; if (pcSel !== 1'b0) begin nFails++; $display("FAIL jal_mis_pcsel: got %b want 0", pcSel); end
    tick();
    idle();
    nChecks++; if (pc !== 32'h30C || misalignTrap !== 1'b1 || flush !== 1'b0) begin nFails++; $display("FAIL jal_mis_trap: got pc=%h trap=%b flush=%b want 30c 1 0", pc, misalignTrap, flush); end
    tick();
    nChecks++; if (misalignTrap !== 1'b0 || pc !== 32'h310) begin nFails++; $display("FAIL jal_mis_pulse: got trap=%b pc=%h want 0 310", misalignTrap, pc); end
  endtask

  task automatic test_stall();
    drive(1, 0, 0, 3'b001, 0, 0, 32'h400);
    stall = 1; #1;
    for (int i = 0; i < 2; i++) begin
      nChecks++; if (pcSel !== 1'b0) begin nFails++; $display("FAIL stall_pcsel%0d: got %b want 0", i, pcSel); end
      tick();
      nChecks++; if (pc !== 32'h310) begin nFails++; $display("FAIL stall_pc%0d: got %h want 310", i, pc); end
    end
    stall = 0; #1;
    nChecks++; if (pcSel !== 1'b1) begin nFails++; $display("FAIL stall_release: got pcSel=%b want 1", pcSel); end
    tick();
    idle();
    nChecks++; if (pc !== 32'h400 || flush !== 1'b1) begin nFails++; $display("FAIL stall_redirect: got pc=%h flush=%b want 400 1", pc, flush); end
    stall = 1; #1;
    tick(); tick();
    nChecks++; if (pc !== 32'h400 || flush !== 1'b1) begin nFails++; $display("FAIL flush_stall: got pc=%h flush=%b want 400 1", pc, flush); end
    stall = 0; #1;
    tick();
    nChecks++; if (pc !== 32'h404 || flush !== 1'b1) begin nFails++; $display("FAIL flush_stretch: got pc=%h flush=%b want 404 1", pc, flush); end
    tick();
    nChecks++; if (pc !== 32'h408 || flush !== 1'b0) begin nFails++; $display("FAIL flush_stretch_end: got pc=%h flush=%b want 408 0", pc, flush); end
  endtask

  task automatic test_illegal();
    drive(1, 0, 0, 3'b010, 1, 1, 32'h800);
    nChecks++; if (pcSel !== 1'b0) begin nFails++; $display("FAIL illegal_pcsel: got %b want 0", pcSel); end
    tick();
    idle();
    nChecks++; if (illegalBr !== 1'b1 || pc !== 32'h40C) begin nFails++; $display("FAIL illegal_pulse: got ill=%b pc=%h want 1 40c", illegalBr, pc); end
    tick();
    nChecks++; if (illegalBr !== 1'b0) begin nFails++; $display("FAIL illegal_clear: got %b want 0", illegalBr); end
    drive(1, 1, 0, 3'b011, 0, 0, 32'h410);  // JAL wins over the branch flag
    tick();
    idle();
    nChecks++; if (illegalBr !== 1'b0 || pc !== 32'h410 || flush !== 1'b1) begin nFails++; $display("FAIL jal_priority: got ill=%b pc=%h flush=%b want 0 410 1", illegalBr, pc, flush); end
    tick(); tick();
  endtask

  task automatic test_reset_in_flush();
    drive(0, 1, 0, 3'b000, 0, 0, 32'h600);
    tick();
    idle();
    nChecks++; if (pc !== 32'h600 || flush !== 1'b1) begin nFails++; $display("FAIL rf_enter: got pc=%h flush=%b want 600 1", pc, flush); end
    rst = 1;
    tick();
    rst = 0;
    nChecks++; if (pc !== 32'h100 || flush !== 1'b0) begin nFails++; $display("FAIL rf_reset: got pc=%h flush=%b want 100 0", pc, flush); end
    drive(0, 1, 0, 3'b000, 0, 0, 32'h700);
    nChecks++; if (pcSel !== 1'b1) begin nFails++; $display("FAIL rf_run: got pcSel=%b want 1", pcSel); end
    tick();
    idle();
    tick(); tick();
  endtask

  task automatic test_wrap();
    drive(0, 1, 0, 3'b000, 0, 0, 32'hFFFF_FFFC);
    tick();
    idle();
    nChecks++; if (pc !== 32'hFFFF_FFFC || pcPlus4 !== 32'h0) begin nFails++; $display("FAIL wrap_pre: got pc=%h pcPlus4=%h want fffffffc 0", pc, pcPlus4); end
    tick();
    nChecks++; if (pc !== 32'h0) begin nFails++; $display("FAIL wrap_pc: got %h want 0", pc); end
    tick();
    nChecks++; if (pc !== 32'h4 || flush !== 1'b0) begin nFails++; $display("FAIL wrap_after: got pc=%h flush=%b want 4 0", pc, flush); end
  endtask

  initial begin
    #200000;
    nFails++;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1;
    idle();
    @(negedge clk);
    test_reset();
    test_blt_flush();
    test_bgeu();
    test_jumps();
    test_stall();
    test_illegal();
    test_reset_in_flush();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Downstream consumer of the branch comparator: takes brEq/brLt, resolves the branch/jump outcome for the instruction in execute, and owns the PC register.
- Drives brUn back to the comparator, and drives the fetch PC, the redirect select and the pipeline flush.
- Sits between the execute stage (comparator, ALU target) and instruction fetch in the RV32I core.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, number of cycles flush stays asserted after a redirect; legal range 1..3.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  freeze PC, state and flush counter this cycle.
- instValid  in  1  execute-stage instruction is real (not a bubble).
- isBranch  in  1  execute instruction is a conditional branch.
- isJal  in  1  execute instruction is JAL.
- isJalr  in  1  execute instruction is JALR.
- funct3  in  3  branch funct3 field.
- brEq  in  1  equality result from the comparator.
- brLt  in  1  less-than result from the comparator.
- aluOut  in  XLEN  computed target (PC+imm or rs1+imm).
- brUn  out  1  unsigned-compare select to the comparator.
- pcSel  out  1  1 = redirect to target this cycle.
- pc  out  XLEN  current fetch PC (registered).
- pcPlus4  out  XLEN  pc + 4 (combinational).
- flush  out  1  kill younger instructions (registered).
- misalignTrap  out  1  one-cycle pulse for a misaligned taken target (registered).
- illegalBr  out  1  one-cycle pulse for reserved funct3 010/011 on a branch (registered).

Behaviour:
- Reset: rst=1 at a clock edge sets pc=RESET_PC, state=RUN, flushCnt=0, flush=0, misalignTrap=0, illegalBr=0. Reset overrides stall and any redirect in flight.
- brUn = funct3[1], purely combinational and independent of isBranch.
- Branch condition by funct3:
  - 000 (BEQ): taken if brEq.
  - 001 (BNE): taken if !brEq.
  - 100 (BLT) and 110 (BLTU): taken if brLt.
  - 101 (BGE) and 111 (BGEU): taken if !brLt.
  - 010/011: not taken; illegalBr pulses next cycle if the instruction is accepted.
- Acceptance: accept = instValid & !stall & (state==RUN).
- Take: take = accept & (isJal | isJalr | (isBranch & cond)).
- Target: target = aluOut with bit 0 cleared when isJalr; aluOut unmodified otherwise.
- Misaligned target: target[1]=1 with take=1 means no redirect (pcSel=0), PC advances sequentially, and misalignTrap=1 for exactly one cycle after the edge.
- pcSel = take & !target[1], combinational, same cycle as the execute inputs.
- Next PC:
  - stall: pc holds.
  - pcSel: pc <= target at the next edge (1-cycle redirect latency).
  - otherwise: pc <= pc + 4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0x0000_0000).
- FSM:
  - RUN -> FLUSH on pcSel; load flushCnt=FLUSH_CYCLES; flush=1 from the next cycle.
  - FLUSH: flush=1; instValid ignored (no take, no trap, no illegalBr); each non-stalled cycle decrements flushCnt and advances pc by 4.
  - FLUSH -> RUN on the edge where flushCnt reaches 0. flush is therefore high for exactly FLUSH_CYCLES non-stalled cycles.
- Stall in FLUSH: counter and flush hold.
- Stall coinciding with a would-be taken branch: no redirect this cycle; the decision re-evaluates on the first non-stalled cycle.
- isJal/isJalr/isBranch with more than one set is a decoder error; priority is JAL > JALR > branch.

Decomposition:
- Shared package core_pkg holds:
  - funct3 branch encodings BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - state enum RUN/FLUSH.
  - XLEN.
  - RESET_PC default.
- One natural sub-module, branch_cond: combinational funct3/brEq/brLt -> cond, illegal. The FSM, PC register and trap logic stay in the top.

Test Plan:
- Reset with RESET_PC=0x100, no instValid for 3 cycles -> pc = 0x100, 0x104, 0x108, 0x10C; flush=0; pcSel=0.
- BLT (funct3=100), brLt=1, aluOut=0x200, pc=0x110 -> brUn=0, pcSel=1, next pc=0x200; flush=1 for 2 cycles; pc=0x204, 0x208 meanwhile; a valid BEQ with brEq=1 during the flush is ignored.
- BGEU (funct3=111), brLt=1 -> brUn=1, not taken, pc+4. Same with brLt=0 and aluOut=0x40 -> redirect to 0x40.
- JALR with aluOut=0x301 -> target 0x300, redirect. JAL with aluOut=0x302 -> no redirect, misalignTrap pulses 1 cycle, pc+4.
- Taken BNE held under stall for 2 cycles -> pc frozen, pcSel=0; the third cycle without stall -> pcSel=1 and redirect. Stall asserted mid-FLUSH -> flush stretched by the stall length.
- funct3=010 branch -> no redirect, illegalBr 1-cycle pulse. rst asserted during FLUSH -> next cycle pc=RESET_PC, flush=0, state RUN. pc=0xFFFF_FFFC sequential -> 0x0000_0000.
